cv32e40x_xif_result_buffer: RTL and testbench



---
 rtl/cv32e40x_pkg.sv | 17 +
 rtl/cv32e40x_xif_result_buffer_if.sv | 40 ++++
 rtl/cv32e40x_xif_result_fifo_ptr.sv | 55 +++++
 rtl/cv32e40x_xif_result_buffer.sv | 114 +++++++++++
 tb/tb_cv32e40x_xif_result_buffer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the eXtension result buffer: the packed result entry that
// travels from the coprocessor execution units to the XIF result channel.
package cv32e40x_pkg;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } xif_result_entry_t;

endpackage

// File: rtl/cv32e40x_xif_result_buffer_if.sv
// Push side (from the execution units) and XIF result side (to the core) of
// the result buffer. "master" is the buffer's own view.
interface cv32e40x_xif_result_buffer_if #(
  parameter int X_ID_WIDTH  = cv32e40x_pkg::X_ID_WIDTH,
  parameter int X_RFW_WIDTH = cv32e40x_pkg::X_RFW_WIDTH
);

  logic                   push_valid_i;
  logic                   push_ready_o;
  logic [X_ID_WIDTH-1:0]  push_id_i;
  logic [X_RFW_WIDTH-1:0] push_data_i;
  logic [4:0]             push_rd_i;
  logic                   push_we_i;
  logic                   push_exc_i;
  logic [5:0]             push_exccode_i;

  logic                   result_valid_o;
  logic                   result_ready_i;
  logic [X_ID_WIDTH-1:0]  result_id_o;
  logic [X_RFW_WIDTH-1:0] result_data_o;
  logic [4:0]             result_rd_o;
  logic                   result_we_o;
  logic                   result_exc_o;
  logic [5:0]             result_exccode_o;

  modport master (
    input  push_valid_i, push_id_i, push_data_i, push_rd_i, push_we_i,
           push_exc_i, push_exccode_i, result_ready_i,
    output push_ready_o, result_valid_o, result_id_o, result_data_o,
           result_rd_o, result_we_o, result_exc_o, result_exccode_o
  );

  modport slave (
    output push_valid_i, push_id_i, push_data_i, push_rd_i, push_we_i,
           push_exc_i, push_exccode_i, result_ready_i,
    input  push_ready_o, result_valid_o, result_id_o, result_data_o,
           result_rd_o, result_we_o, result_exc_o, result_exccode_o
  );

endinterface

// File: rtl/cv32e40x_xif_result_fifo_ptr.sv
// Read/write pointers with a wrap bit, plus full/empty/count derived from them.
module cv32e40x_xif_result_fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH)-1:0] wr_idx_o,
  output logic [$clog2(DEPTH)-1:0] rd_idx_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_idx_o = wr_ptr_q[AW-1:0];
  assign rd_idx_o = rd_ptr_q[AW-1:0];
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o  = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order result FIFO feeding the XIF result channel. Define
// CV32E40X_XIF_RESULT_BYPASS_EN to let a push reach an empty channel in the same cycle.
module cv32e40x_xif_result_buffer
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  cv32e40x_xif_result_buffer_if.master xif,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int AW = $clog2(DEPTH);

  xif_result_entry_t mem_q [DEPTH];
  xif_result_entry_t push_entry;
  xif_result_entry_t head;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              full, empty;
  logic              push_en, pop_en, bypass_pop, head_valid;

  assign push_entry = '{id:      xif.push_id_i,
                        data:    xif.push_data_i,
                        rd:      xif.push_rd_i,
                        we:      xif.push_we_i,
                        exc:     xif.push_exc_i,
                        exccode: xif.push_exccode_i};

`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
  // An empty buffer hands an accepted push straight to the core; nothing is stored.
  assign bypass_pop = empty && xif.push_valid_i && xif.result_ready_i && !flush_i;
`else
  assign bypass_pop = 1'b0;
`endif

  assign push_en = xif.push_valid_i && !full && !flush_i && !bypass_pop;
  assign pop_en  = !empty && xif.result_ready_i && !flush_i;

  cv32e40x_xif_result_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .push_i   (push_en),
    .pop_i    (pop_en),
    .wr_idx_o (wr_idx),
    .rd_idx_o (rd_idx),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count_o)
  );

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are live, and empty slots never reach the outputs.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_idx] <= push_entry;
  end

  always_comb begin
    head       = '0;
    head_valid = 1'b0;
    if (!empty) begin
      head       = mem_q[rd_idx];
      head_valid = 1'b1;
    end
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
    else if (xif.push_valid_i && !flush_i) begin
      head       = push_entry;
      head_valid = 1'b1;
    end
`endif
  end

  assign xif.push_ready_o     = !full;
  assign xif.result_valid_o   = head_valid;
  assign xif.result_id_o      = head.id;
  assign xif.result_data_o    = head.data;
  assign xif.result_rd_o      = head.rd;
  assign xif.result_we_o      = head.we;
  assign xif.result_exc_o     = head.exc;
  assign xif.result_exccode_o = head.exccode;

`ifndef SYNTHESIS
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic              hold_q;
  xif_result_entry_t held_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else begin
      hold_q <= head_valid && !xif.result_ready_i && !flush_i;
      held_q <= head;
    end
  end

  // Sampled before the edge updates state: hold_q describes the cycle before the one observed.
  always @(posedge clk) begin
    if (!rst) begin
      if (hold_q) begin
        assert (head_valid && (head == held_q))
          else $error("result channel changed while stalled");
      end
      assert (!(push_en && full))  else $error("push into a full buffer");
      assert (!(pop_en && empty))  else $error("pop from an empty buffer");
      assert (count_o <= DEPTH_CNT) else $error("count exceeds depth");
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
// Directed and random stimulus for the result buffer, checked against a
// queue-based model of the result channel.
module tb_cv32e40x_xif_result_buffer;
  import cv32e40x_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] count;

  cv32e40x_xif_result_buffer_if xif ();

  cv32e40x_xif_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .xif     (xif.master),
    .count_o (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  xif_result_entry_t model_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic xif_result_entry_t mk(input int id, input logic [31:0] data,
                                           input logic [4:0] rd, input logic we,
                                           input logic exc, input logic [5:0] code);
    xif_result_entry_t e;
    e.id      = 4'(id);
    e.data    = data;
    e.rd      = rd;
    e.we      = we;
    e.exc     = exc;
    e.exccode = code;
    return e;
  endfunction

  function automatic xif_result_entry_t rnd_entry(input int id);
    return mk(id, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 6'($urandom));
  endfunction

  function automatic logic [63:0] dut_head();
    return 64'({xif.result_id_o, xif.result_data_o, xif.result_rd_o,
                xif.result_we_o, xif.result_exc_o, xif.result_exccode_o});
  endfunction

  task automatic drive(input bit pv, input xif_result_entry_t pe, input bit rr, input bit fl);
    xif.push_valid_i   = pv;
    xif.push_id_i      = pe.id;
    xif.push_data_i    = pe.data;
    xif.push_rd_i      = pe.rd;
    xif.push_we_i      = pe.we;
    xif.push_exc_i     = pe.exc;
    xif.push_exccode_i = pe.exccode;
    xif.result_ready_i = rr;
    flush              = fl;
  endtask

  // One clock cycle: apply inputs, compare the channel with the model, advance the model.
  task automatic step(input bit pv, input xif_result_entry_t pe, input bit rr, input bit fl,
                      input string tag);
    bit                exp_valid;
    bit                byp;
    bit                room;
    xif_result_entry_t exp_head;
    drive(pv, pe, rr, fl);
    #1;
    byp       = 1'b0;
    room      = model_q.size() < DEPTH;
    exp_valid = model_q.size() != 0;
    exp_head  = exp_valid ? model_q[0] : '0;
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
    if (!exp_valid && pv && !fl) begin
      exp_valid = 1'b1;
      exp_head  = pe;
      byp       = 1'b1;
    end
`endif
    check({tag, ".valid"}, 64'(xif.result_valid_o), 64'(exp_valid));
    check({tag, ".head"},  dut_head(),              64'(exp_head));
    check({tag, ".ready"}, 64'(xif.push_ready_o),   64'(room));
    check({tag, ".count"}, 64'(count),              64'(model_q.size()));
    if (fl) begin
      model_q.delete();
    end else begin
      if (exp_valid && rr && !byp) void'(model_q.pop_front());
      if (pv && room && !(byp && rr)) model_q.push_back(pe);
    end
    @(posedge clk);
    #1;
  endtask

  xif_result_entry_t idle_e;

  initial begin
    idle_e = '0;
    rst    = 1'b1;
    drive(1'b0, idle_e, 1'b0, 1'b0);
    #2;
    check("reset.valid", 64'(xif.result_valid_o), 64'd0);
    check("reset.count", 64'(count),              64'd0);
    check("reset.ready", 64'(xif.push_ready_o),   64'd1);
    check("reset.data",  64'(xif.result_data_o),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single result held for five stalled cycles, then accepted.
    step(1'b1, mk(3, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 6'd0), 1'b0, 1'b0, "single.push");
    for (int i = 0; i < 5; i++) step(1'b0, idle_e, 1'b0, 1'b0, "single.hold");
    step(1'b0, idle_e, 1'b1, 1'b0, "single.pop");
    step(1'b0, idle_e, 1'b0, 1'b0, "single.after");

    // Fill to DEPTH, try to overfill (also with a simultaneous pop), then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_entry(i), 1'b0, 1'b0, "fill.push");
    step(1'b1, rnd_entry(4), 1'b0, 1'b0, "fill.over");
    step(1'b1, rnd_entry(5), 1'b1, 1'b0, "fill.over_pop");
    for (int i = 0; i < DEPTH; i++) step(1'b0, idle_e, 1'b1, 1'b0, "fill.drain");

    // Back-to-back push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, rnd_entry(i), 1'b1, 1'b0, "wrap");
    step(1'b0, idle_e, 1'b1, 1'b0, "wrap.drain");
    step(1'b0, idle_e, 1'b0, 1'b0, "wrap.empty");

    // Flush wins over a concurrent push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, rnd_entry(i), 1'b0, 1'b0, "flush.fill");
    step(1'b1, mk(7, 32'h0000_0007, 5'd7, 1'b1, 1'b0, 6'd0), 1'b1, 1'b1, "flush.hit");
    step(1'b0, idle_e, 1'b1, 1'b0, "flush.after");

    // Push into an empty buffer with the core ready.
    step(1'b1, mk(2, 32'h1234_5678, 5'd2, 1'b1, 1'b0, 6'd0), 1'b1, 1'b0, "empty.push");
    step(1'b0, idle_e, 1'b1, 1'b0, "empty.next");
    step(1'b0, idle_e, 1'b0, 1'b0, "empty.idle");

    // Asynchronous reset in the middle of traffic.
    step(1'b1, rnd_entry(8), 1'b0, 1'b0, "rst.fill");
    step(1'b1, rnd_entry(9), 1'b0, 1'b0, "rst.fill");
    drive(1'b0, idle_e, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid.valid", 64'(xif.result_valid_o), 64'd0);
    check("rst_mid.count", 64'(count),              64'd0);
    check("rst_mid.ready", 64'(xif.push_ready_o),   64'd1);
    check("rst_mid.data",  64'(xif.result_data_o),  64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, idle_e, 1'b0, 1'b0, "rst.after");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), rnd_entry(i), 1'($urandom), ($urandom_range(31) == 0), "rand");
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, idle_e, 1'b1, 1'b0, "final.drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
